// File: rtl/icache_fetch_responder.sv
// Direct-mapped read-only instruction cache: combinational hit path, one-block refill FSM.
// Optional hit/miss statistics counters enabled by defining ICACHE_STATS_EN.
module icache_fetch_responder #(
  parameter int unsigned LINE_COUNT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          is_input_valid,
  input  logic [31:0]   addr,
  output logic [31:0]   dout,
  output logic          is_output_valid,
  output logic          is_cache_stall,
  output logic          mem_req,
  output logic [31:0]   mem_addr,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [127:0]  mem_rdata,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
);

  localparam int unsigned IDX_W = $clog2(LINE_COUNT);
  localparam int unsigned TAG_W = 28 - IDX_W;

  localparam logic [1:0] ST_READY     = 2'd0;
  localparam logic [1:0] ST_MISS_REQ  = 2'd1;
  localparam logic [1:0] ST_MISS_WAIT = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [LINE_COUNT-1:0] valid;
  logic [TAG_W-1:0] tags [LINE_COUNT];
  logic [127:0]     data [LINE_COUNT];
  logic [27:0]      miss_blk;
  logic             miss_start;
  logic             fill;

  logic [1:0]       offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] fill_idx;
  logic [127:0]     line;
  logic [31:0]      word_sel;
  logic             unused_addr_bits;

  assign offset           = addr[3:2];
  assign index            = addr[4 +: IDX_W];
  assign tag              = addr[31 -: TAG_W];
  assign fill_idx         = miss_blk[IDX_W-1:0];
  assign line             = data[index];
  assign mem_addr         = {miss_blk, 4'b0000};
  assign unused_addr_bits = ^addr[1:0];

  always_comb begin
    word_sel = line[31:0];
    case (offset)
      2'd1:    word_sel = line[63:32];
      2'd2:    word_sel = line[95:64];
      2'd3:    word_sel = line[127:96];
      default: word_sel = line[31:0];
    endcase
  end

  // State register and refill bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_READY;
      valid    <= '0;
      miss_blk <= '0;
      mem_req  <= 1'b0;
    end else begin
      state   <= state_next;
      mem_req <= (state_next == ST_MISS_REQ);
      if (miss_start) miss_blk <= addr[31:4];
      if (fill) valid[fill_idx] <= 1'b1;
    end
  end

  // Tag/data arrays need no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (!reset && fill) begin
      data[fill_idx] <= mem_rdata;
      tags[fill_idx] <= miss_blk[27 -: TAG_W];
    end
  end

  // Next state plus the zero-latency lookup outputs.
  always_comb begin
    state_next      = state;
    dout            = 32'd0;
    is_output_valid = 1'b0;
    is_cache_stall  = 1'b0;
    miss_start      = 1'b0;
    fill            = 1'b0;
    case (state)
      ST_READY: begin
        if (is_input_valid) begin
          if (valid[index] && (tags[index] == tag)) begin
            is_output_valid = 1'b1;
            dout            = word_sel;
          end else begin
            is_cache_stall = 1'b1;
            miss_start     = 1'b1;
            state_next     = ST_MISS_REQ;
          end
        end
      end
      ST_MISS_REQ: begin
        is_cache_stall = 1'b1;
        if (mem_ready) state_next = ST_MISS_WAIT;
      end
      ST_MISS_WAIT: begin
        is_cache_stall = 1'b1;
        if (mem_rvalid) begin
          fill       = 1'b1;
          state_next = ST_READY;
        end
      end
      default: state_next = ST_READY;
    endcase
  end

`ifdef ICACHE_STATS_EN
  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (is_output_valid && (hit_count != 32'hFFFF_FFFF))
        hit_count <= hit_count + 32'd1;
      if (miss_start && (miss_count != 32'hFFFF_FFFF))
        miss_count <= miss_count + 32'd1;
    end
  end
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Directed self-checking bench for icache_fetch_responder with a small latency-programmable memory.
module tb_icache_fetch_responder;

  logic         clk;
  logic         reset;
  logic         is_input_valid;
  logic [31:0]  addr;
  logic [31:0]  dout;
  logic         is_output_valid;
  logic         is_cache_stall;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ready;
  logic         mem_rvalid;
  logic [127:0] mem_rdata;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int checks = 0;
  int errors = 0;

  // Memory model controls
  int          rv_delay  = 3;
  logic        auto_resp = 1'b1;
  logic        manual_rv = 1'b0;
  int          cnt       = 0;
  logic [31:0] pend      = 32'd0;
  logic        accepted;
  logic [31:0] acc_addr;

  icache_fetch_responder #(.LINE_COUNT(16)) dut (
    .clk(clk), .reset(reset), .is_input_valid(is_input_valid), .addr(addr),
    .dout(dout), .is_output_valid(is_output_valid), .is_cache_stall(is_cache_stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'd0) ? 32'h0000_0013 : (a ^ 32'hC0DE_0000);
  endfunction

  function automatic logic [127:0] blk(input logic [31:0] a);
    logic [127:0] b;
    logic [31:0]  base;
    base = {a[31:4], 4'b0000};
    for (int k = 0; k < 4; k++) b[32*k +: 32] = mem_word(base + 32'(4*k));
    return b;
  endfunction

  // rvalid is raised rv_delay cycles after the accepting edge (1 = the very next cycle).
  always @(posedge clk) begin
    accepted = mem_req && mem_ready;
    acc_addr = mem_addr;
    #1;
    mem_rvalid = 1'b0;
    if (accepted && auto_resp) begin
      cnt  = rv_delay;
      pend = acc_addr;
    end
    if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = blk(pend);
      end
    end
    if (manual_rv) begin
      mem_rvalid = 1'b1;
      mem_rdata  = blk(32'h0000_0300);
    end
  end

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_stall_low(output int n);
    n = 0;
    while (is_cache_stall && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; is_input_valid = 1'b0; addr = 32'd0; mem_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    checks++;
    if ({is_cache_stall, is_output_valid, mem_req} !== 3'b000 || dout !== 32'd0 || mem_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: stall/ovalid/req=%b dout=%h mem_addr=%h required 000/0/0",
               {is_cache_stall, is_output_valid, mem_req}, dout, mem_addr);
    end
    checks++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters: hit=%0d miss=%0d required 0 0", hit_count, miss_count);
    end
  endtask

  task automatic test_cold_miss;
    int n;
    rv_delay = 3;
    addr = 32'h0000_0000; is_input_valid = 1'b1;
    #1;
    checks++;
    if (is_cache_stall !== 1'b1) begin
      errors++; $display("FAIL cold_c0_stall: got %b required 1", is_cache_stall);
    end
    wait_stall_low(n);
    checks++;
    if (n != 5) begin
      errors++; $display("FAIL cold_stall_len: got %0d required 5", n);
    end
    checks++;
    if (is_output_valid !== 1'b1 || dout !== 32'h0000_0013) begin
      errors++; $display("FAIL cold_hit: ovalid=%b dout=%h required 1 00000013", is_output_valid, dout);
    end
    checks++;
`ifdef ICACHE_STATS_EN
    if (miss_count !== 32'd1) begin
      errors++; $display("FAIL cold_miss_count: got %0d required 1", miss_count);
    end
`else
    if (miss_count !== 32'd0) begin
      errors++; $display("FAIL cold_miss_count: got %0d required 0", miss_count);
    end
`endif
  endtask

  task automatic test_sequential_hits;
    logic [31:0] exp_w [3];
    exp_w[0] = 32'hC0DE_0004; exp_w[1] = 32'hC0DE_0008; exp_w[2] = 32'hC0DE_000C;
    step();
    for (int i = 0; i < 3; i++) begin
      addr = 32'(4 * (i + 1));
      #1;
      checks++;
      if (is_output_valid !== 1'b1 || is_cache_stall !== 1'b0 || dout !== exp_w[i]) begin
        errors++;
        $display("FAIL seq_hit_%0d: ovalid=%b stall=%b dout=%h required 1 0 %h",
                 i, is_output_valid, is_cache_stall, dout, exp_w[i]);
      end
      step();
    end
    is_input_valid = 1'b0;
    step();
    checks++;
`ifdef ICACHE_STATS_EN
    // Cold-miss completing hit on 0x00 plus the three sequential hits.
    if (hit_count !== 32'd4) begin
      errors++; $display("FAIL seq_hit_count: got %0d required 4", hit_count);
    end
`else
    if (hit_count !== 32'd0) begin
      errors++; $display("FAIL seq_hit_count: got %0d required 0", hit_count);
    end
`endif
  endtask

  task automatic test_conflict_eviction;
    int n;
    addr = 32'h0000_0100; is_input_valid = 1'b1;
    #1;
    checks++;
    if (is_cache_stall !== 1'b1 || is_output_valid !== 1'b0) begin
      errors++; $display("FAIL alias_miss: stall=%b ovalid=%b required 1 0", is_cache_stall, is_output_valid);
    end
    wait_stall_low(n);
    checks++;
    if (n != 5 || dout !== 32'hC0DE_0100) begin
      errors++; $display("FAIL alias_fill: stall_len=%0d dout=%h required 5 c0de0100", n, dout);
    end
    addr = 32'h0000_0000;
    #1;
    checks++;
    if (is_cache_stall !== 1'b1 || is_output_valid !== 1'b0) begin
      errors++; $display("FAIL evicted_remiss: stall=%b ovalid=%b required 1 0", is_cache_stall, is_output_valid);
    end
    wait_stall_low(n);
    checks++;
    if (dout !== 32'h0000_0013) begin
      errors++; $display("FAIL evicted_refill: dout=%h required 00000013", dout);
    end
    checks++;
`ifdef ICACHE_STATS_EN
    if (miss_count !== 32'd3) begin
      errors++; $display("FAIL alias_miss_count: got %0d required 3", miss_count);
    end
`else
    if (miss_count !== 32'd0) begin
      errors++; $display("FAIL alias_miss_count: got %0d required 0", miss_count);
    end
`endif
    is_input_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure;
    int n;
    mem_ready = 1'b0;
    addr = 32'h0000_0250; is_input_valid = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0250 || is_cache_stall !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d: req=%b mem_addr=%h stall=%b required 1 00000250 1",
                 i, mem_req, mem_addr, is_cache_stall);
      end
      if (i == 4) mem_ready = 1'b1;
      else step();
    end
    step();
    checks++;
    if (mem_req !== 1'b0 || is_cache_stall !== 1'b1) begin
      errors++; $display("FAIL bp_wait: req=%b stall=%b required 0 1", mem_req, is_cache_stall);
    end
    wait_stall_low(n);
    checks++;
    if (is_output_valid !== 1'b1 || dout !== 32'hC0DE_0250) begin
      errors++; $display("FAIL bp_fill: ovalid=%b dout=%h required 1 c0de0250", is_output_valid, dout);
    end
    is_input_valid = 1'b0;
    step();
  endtask

  task automatic test_addr_change;
    int n;
    rv_delay = 3;
    addr = 32'h0000_0040; is_input_valid = 1'b1;
    step();
    step();
    addr = 32'h0000_0080;
    n = 0;
    while (!mem_req && n < 20) begin
      n++;
      step();
    end
    checks++;
    if (n != 4 || mem_addr !== 32'h0000_0080 || is_cache_stall !== 1'b1) begin
      errors++;
      $display("FAIL chg_new_miss: cycles=%0d mem_addr=%h stall=%b required 4 00000080 1",
               n, mem_addr, is_cache_stall);
    end
    wait_stall_low(n);
    checks++;
    if (dout !== 32'hC0DE_0080 || is_output_valid !== 1'b1) begin
      errors++; $display("FAIL chg_fill_80: dout=%h ovalid=%b required c0de0080 1", dout, is_output_valid);
    end
    addr = 32'h0000_0040;
    #1;
    checks++;
    if (dout !== 32'hC0DE_0040 || is_output_valid !== 1'b1 || is_cache_stall !== 1'b0) begin
      errors++;
      $display("FAIL chg_40_valid: dout=%h ovalid=%b stall=%b required c0de0040 1 0",
               dout, is_output_valid, is_cache_stall);
    end
    is_input_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_refill;
    int n;
    auto_resp = 1'b0;
    addr = 32'h0000_0300; is_input_valid = 1'b1;
    step();
    step();
    checks++;
    if (mem_req !== 1'b0 || is_cache_stall !== 1'b1) begin
      errors++; $display("FAIL rst_mid_wait: req=%b stall=%b required 0 1", mem_req, is_cache_stall);
    end
    reset = 1'b1; is_input_valid = 1'b0;
    step();
    reset = 1'b0;
    checks++;
    if (is_cache_stall !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'd0 ||
        hit_count !== 32'd0 || miss_count !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_state: stall=%b req=%b mem_addr=%h hit=%0d miss=%0d required 0 0 0 0 0",
               is_cache_stall, mem_req, mem_addr, hit_count, miss_count);
    end
    manual_rv = 1'b1;
    step();
    manual_rv = 1'b0;
    step();
    addr = 32'h0000_0300; is_input_valid = 1'b1;
    #1;
    checks++;
    if (is_cache_stall !== 1'b1 || is_output_valid !== 1'b0) begin
      errors++; $display("FAIL rst_late_rvalid: stall=%b ovalid=%b required 1 0", is_cache_stall, is_output_valid);
    end
    auto_resp = 1'b1;
    wait_stall_low(n);
    checks++;
    if (n != 5 || dout !== 32'hC0DE_0300) begin
      errors++; $display("FAIL rst_refill: stall_len=%0d dout=%h required 5 c0de0300", n, dout);
    end
    addr = 32'h0000_0000;
    #1;
    checks++;
    if (is_cache_stall !== 1'b1) begin
      errors++; $display("FAIL rst_lines_invalid: stall=%b required 1", is_cache_stall);
    end
    wait_stall_low(n);
    is_input_valid = 1'b0;
    step();
  endtask

  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    test_reset();
    test_cold_miss();
    test_sequential_hits();
    test_conflict_eviction();
    test_backpressure();
    test_addr_change();
    test_reset_mid_refill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
